// File: rtl/song_reader.sv
// Song sequencer: walks an external song ROM and hands one note at a time to note_player.
// Optional SONG_LOOP_EN restarts the song from index 0 instead of holding at the end.
module song_reader #(
  parameter int unsigned SONG_BITS = 2,
  parameter int unsigned IDX_BITS  = 5,
  parameter int unsigned ROM_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          note_done,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [11:0]                   rom_data,
  output logic [5:0]                    note_to_load,
  output logic [5:0]                    duration_to_load,
  output logic                          new_note,
  output logic                          song_done
);

  localparam int unsigned CNT_W = 2;
  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;
  localparam logic [CNT_W-1:0]    LAT_LAST = CNT_W'(ROM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_WAIT,
    S_END
  } state_t;

  state_t               state;
  logic [SONG_BITS-1:0] song_q;
  logic [IDX_BITS-1:0]  index;
  logic [CNT_W-1:0]     lat_cnt;

  // Address is built only from registered state, so it is glitch-free.
  assign rom_addr = {song_q, index};

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      song_q           <= '0;
      index            <= '0;
      lat_cnt          <= '0;
      note_to_load     <= '0;
      duration_to_load <= '0;
      new_note         <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      new_note <= 1'b0;
      // Dropping play aborts from anywhere and takes priority over note_done.
      if (state != S_IDLE && !play) begin
        state     <= S_IDLE;
        song_q    <= '0;
        index     <= '0;
        lat_cnt   <= '0;
        song_done <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            song_q    <= song;
            index     <= '0;
            lat_cnt   <= '0;
            song_done <= 1'b0;
            if (play) state <= S_FETCH;
          end
          S_FETCH: begin
            if (lat_cnt == LAT_LAST) begin
              lat_cnt <= '0;
              state   <= S_CHECK;
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
          S_CHECK: begin
            if (rom_data == 12'h000) begin
              song_done <= 1'b1;
              state     <= S_END;
            end else begin
              note_to_load     <= rom_data[11:6];
              duration_to_load <= rom_data[5:0];
              new_note         <= 1'b1;
              state            <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (note_done) begin
              if (index == IDX_LAST) begin
                song_done <= 1'b1;
                state     <= S_END;
              end else begin
                index <= index + 1'b1;
                state <= S_FETCH;
              end
            end
          end
          S_END: begin
`ifdef SONG_LOOP_EN
            song_done <= 1'b0;
            index     <= '0;
            state     <= S_FETCH;
`else
            song_done <= 1'b1;
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Randomized directed bench for song_reader against a note-list model of the song ROM.
module tb_song_reader;

  localparam int ROM_LAT = 1;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        new_note;
  logic        song_done;

  logic [11:0] rom [128];
  logic [11:0] rom_q1;
  logic [11:0] rom_q2;

  int total = 0;
  int bad   = 0;

  song_reader #(.SONG_BITS(2), .IDX_BITS(5), .ROM_LAT(ROM_LAT)) dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song             (song),
    .note_done        (note_done),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .new_note         (new_note),
    .song_done        (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM with ROM_LAT cycles of read latency.
  always_ff @(posedge clk) begin
    rom_q1 <= rom[rom_addr];
    rom_q2 <= rom_q1;
  end
  assign rom_data = (ROM_LAT == 2) ? rom_q2 : rom_q1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts in the first fetch cycle after a trigger; ends in the cycle the note (or end) shows.
  task automatic expect_note(input int s, input int i);
    logic [11:0] e;
    e = rom[7'(s * 32 + i)];
    chk("fetch_addr", 32'(rom_addr), 32'(s * 32 + i));
    for (int k = 0; k < ROM_LAT; k++) begin
      chk("fetch_no_note", 32'(new_note), 0);
      tick();
    end
    chk("check_no_note", 32'(new_note), 0);
    tick();
    if (e == 12'h000) begin
      chk("marker_no_note", 32'(new_note), 0);
      chk("marker_done", 32'(song_done), 1);
    end else begin
      chk("new_note", 32'(new_note), 1);
      chk("note", 32'(note_to_load), 32'(e[11:6]));
      chk("duration", 32'(duration_to_load), 32'(e[5:0]));
      chk("not_done", 32'(song_done), 0);
    end
  endtask

  // Random wait in WAIT while wiggling the song select, which must be ignored.
  task automatic gap();
    int n;
    n = int'($urandom_range(0, 4));
    for (int k = 0; k < n; k++) begin
      song = 2'($urandom_range(0, 3));
      tick();
      chk("gap_no_note", 32'(new_note), 0);
    end
  endtask

  task automatic pulse_done();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
  endtask

  task automatic run_song(input int s);
    song = 2'(s);
    play = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      expect_note(s, i);
      if (rom[7'(s * 32 + i)] == 12'h000) return;
      gap();
      pulse_done();
    end
    chk("last_done", 32'(song_done), 1);
    chk("last_no_note", 32'(new_note), 0);
`ifdef SONG_LOOP_EN
    tick();
    chk("loop_done_drop", 32'(song_done), 0);
    expect_note(s, 0);
`endif
  endtask

  task automatic finish_song();
`ifndef SONG_LOOP_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("end_hold", 32'(song_done), 1);
      chk("end_no_note", 32'(new_note), 0);
    end
    pulse_done();
    chk("end_ignore_done", 32'(song_done), 1);
    chk("end_ignore_note", 32'(new_note), 0);
`endif
    play = 1'b0;
    tick();
    chk("stop_done_low", 32'(song_done), 0);
    chk("stop_no_note", 32'(new_note), 0);
  endtask

  initial begin
    int hits;
    int m;
    reset = 1'b1;
    play = 1'b0;
    note_done = 1'b0;
    song = 2'd0;
    for (int a = 0; a < 128; a++) rom[a] = 12'($urandom_range(1, 4095));
    rom[64] = 12'h283;
    rom[65] = {6'($urandom_range(1, 63)), 6'd0};
    rom[66] = 12'h000;
    m = int'($urandom_range(1, 31));
    rom[7'(96 + m)] = 12'h000;

    tick();
    chk("rst_new_note", 32'(new_note), 0);
    chk("rst_song_done", 32'(song_done), 0);
    chk("rst_note", 32'(note_to_load), 0);
    chk("rst_dur", 32'(duration_to_load), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    tick();
    reset = 1'b0;

    // First note of song 2, then reset while in WAIT.
    song = 2'd2;
    play = 1'b1;
    tick();
    expect_note(2, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    play = 1'b0;
    chk("mid_rst_new_note", 32'(new_note), 0);
    chk("mid_rst_done", 32'(song_done), 0);
    chk("mid_rst_note", 32'(note_to_load), 0);
    chk("mid_rst_dur", 32'(duration_to_load), 0);
    chk("mid_rst_addr", 32'(rom_addr), 0);
    tick();

    // Song 2: hold in WAIT, zero-duration note, then end marker.
    song = 2'd2;
    play = 1'b1;
    tick();
    expect_note(2, 0);
    hits = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (new_note) hits++;
    end
    chk("idle_100_no_note", 32'(hits), 0);
    pulse_done();
    expect_note(2, 1);
    gap();
    pulse_done();
    expect_note(2, 2);
    finish_song();
    song = 2'd2;
    play = 1'b1;
    tick();
    expect_note(2, 0);
    play = 1'b0;
    tick();

    run_song(1);
    finish_song();
    run_song(3);
    finish_song();

    // play drops while the ROM read is in flight.
    song = 2'd0;
    play = 1'b1;
    tick();
    play = 1'b0;
    tick();
    chk("abort_fetch_idx", 32'(rom_addr[4:0]), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_fetch_no_note", 32'(new_note), 0);
    end

    // play drops in the same cycle as note_done.
    play = 1'b1;
    tick();
    expect_note(0, 0);
    pulse_done();
    expect_note(0, 1);
    gap();
    note_done = 1'b1;
    play = 1'b0;
    tick();
    note_done = 1'b0;
    chk("abort_done_idx", 32'(rom_addr[4:0]), 0);
    chk("abort_done_no_note", 32'(new_note), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_done_quiet", 32'(new_note), 0);
    end
    song = 2'd0;
    play = 1'b1;
    tick();
    expect_note(0, 0);
    play = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
